// File: rtl/alu_defs.sv
// alu_defs: shared definitions for the sequential ALU and the control unit.
//   - ALUOP encodings (3-bit SELECT values)
//   - FSM state encodings for alu_seq
//   - is_shift(): true for the three iterative shift opcodes
// Optional feature macro (used by the including files): ALU_SEQ_MUL_EN.
package alu_defs;

  localparam logic [2:0] ALU_FWD = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SRA = 3'b110;
  localparam logic [2:0] ALU_MUL = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  function automatic logic is_shift(input logic [2:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// alu_iter_unit: captured operands, iteration counter and the
// shift / shift-add multiply datapath of alu_seq.
// Optional feature macro: ALU_SEQ_MUL_EN (adds the multiply accumulator).
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_load         capture i_op/i_data1/i_data2 and preset the counter
//   i_step         advance one iteration (asserted every EXEC cycle)
//   i_op           ALUOP to capture
//   i_data1        operand 1
//   i_data2        operand 2 / shift amount
//   o_last         current EXEC cycle is the final one
//   o_reserved     captured op is a reserved opcode
//   o_result       value the op produces at the end of this cycle
module alu_iter_unit
  import alu_defs::*;
#(
  parameter int DATA_W  = 8,
  parameter int SHAMT_W = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic              i_step,
  input  logic [2:0]        i_op,
  input  logic [DATA_W-1:0] i_data1,
  input  logic [DATA_W-1:0] i_data2,
  output logic              o_last,
  output logic              o_reserved,
  output logic [DATA_W-1:0] o_result
);

  // Counter must hold DATA_W for the multiply, not just a shift amount.
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [2:0]        r_op;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] w_shift1;
  logic [CNT_W-1:0]  w_cnt_init;

  always_comb begin
    w_shift1 = r_a;
    case (r_op)
      ALU_SLL: w_shift1 = {r_a[DATA_W-2:0], 1'b0};
      ALU_SRL: w_shift1 = {1'b0, r_a[DATA_W-1:1]};
      ALU_SRA: w_shift1 = {r_a[DATA_W-1], r_a[DATA_W-1:1]};
      default: w_shift1 = r_a;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  // Shift-add multiply: r_a is the multiplicand moving left, r_b the
  // multiplier moving right; each step adds r_a when r_b's LSB is set.
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] w_acc_next;

  assign w_acc_next = r_acc + (r_b[0] ? r_a : '0);
  assign o_reserved = 1'b0;
`else
  assign o_reserved = (r_op == ALU_MUL);
`endif

  always_comb begin
    w_cnt_init = '0;
    if (is_shift(i_op)) begin
      w_cnt_init = CNT_W'(i_data2[SHAMT_W-1:0]);
    end
`ifdef ALU_SEQ_MUL_EN
    else if (i_op == ALU_MUL) begin
      w_cnt_init = CNT_W'(DATA_W);
    end
`endif
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_op  <= ALU_FWD;
      r_a   <= '0;
      r_b   <= '0;
      r_cnt <= '0;
`ifdef ALU_SEQ_MUL_EN
      r_acc <= '0;
`endif
    end else if (i_load) begin
      r_op  <= i_op;
      r_a   <= i_data1;
      r_b   <= i_data2;
      r_cnt <= w_cnt_init;
`ifdef ALU_SEQ_MUL_EN
      r_acc <= '0;
`endif
    end else if (i_step) begin
      if (is_shift(r_op) && (r_cnt != '0)) begin
        r_a   <= w_shift1;
        r_cnt <= r_cnt - CNT_ONE;
      end
`ifdef ALU_SEQ_MUL_EN
      else if ((r_op == ALU_MUL) && (r_cnt != '0)) begin
        r_acc <= w_acc_next;
        r_a   <= {r_a[DATA_W-2:0], 1'b0};
        r_b   <= {1'b0, r_b[DATA_W-1:1]};
        r_cnt <= r_cnt - CNT_ONE;
      end
`endif
    end
  end

  // k=0 shifts and all single-cycle ops finish in their first EXEC cycle.
  always_comb begin
    o_last = 1'b1;
    if (is_shift(r_op)) begin
      o_last = (r_cnt <= CNT_ONE);
    end
`ifdef ALU_SEQ_MUL_EN
    else if (r_op == ALU_MUL) begin
      o_last = (r_cnt == CNT_ONE);
    end
`endif
  end

  always_comb begin
    o_result = r_a;
    case (r_op)
      ALU_FWD: o_result = r_b;
      ALU_ADD: o_result = r_a + r_b;
      ALU_AND: o_result = r_a & r_b;
      ALU_OR:  o_result = r_a | r_b;
      ALU_SLL,
      ALU_SRL,
      ALU_SRA: o_result = (r_cnt == '0) ? r_a : w_shift1;
`ifdef ALU_SEQ_MUL_EN
      ALU_MUL: o_result = w_acc_next;
`endif
      default: o_result = r_a;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: clocked ALU with START/DONE handshake. Single-cycle ops
// (FORWARD/ADD/AND/OR) and iterative shifts, plus optional multiply.
// Optional feature macro: ALU_SEQ_MUL_EN (SELECT=111 multiply; reserved otherwise).
// Ports:
//   CLK     clock
//   RESET   asynchronous active-high reset
//   START   request, sampled only in IDLE
//   SELECT  ALUOP, captured with START
//   DATA1   operand 1, captured with START
//   DATA2   operand 2 / shift amount, captured with START
//   RESULT  registered result, updated only at the edge raising DONE
//   ZERO    registered (RESULT == 0)
//   BUSY    high in EXEC and FIN
//   DONE    one-cycle completion pulse
//   ERR     pulses with DONE for a reserved SELECT
module alu_seq
  import alu_defs::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic [2:0]        SELECT,
  input  logic [DATA_W-1:0] DATA1,
  input  logic [DATA_W-1:0] DATA2,
  output logic [DATA_W-1:0] RESULT,
  output logic              ZERO,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR
);

  localparam int SHAMT_W = $clog2(DATA_W);

  state_t            r_state;
  state_t            w_state_next;
  logic              w_load;
  logic              w_step;
  logic              w_last;
  logic              w_reserved;
  logic [DATA_W-1:0] w_res;
  logic [DATA_W-1:0] r_result;
  logic              r_zero;
  logic              r_err;

  assign w_load = (r_state == S_IDLE) && START;
  assign w_step = (r_state == S_EXEC);

  alu_iter_unit #(
    .DATA_W  (DATA_W),
    .SHAMT_W (SHAMT_W)
  ) u_iter (
    .i_clk      (CLK),
    .i_rst      (RESET),
    .i_load     (w_load),
    .i_step     (w_step),
    .i_op       (SELECT),
    .i_data1    (DATA1),
    .i_data2    (DATA2),
    .o_last     (w_last),
    .o_reserved (w_reserved),
    .o_result   (w_res)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (START) w_state_next = S_EXEC;
      S_EXEC:  if (w_last) w_state_next = S_FIN;
      S_FIN:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Result/flags load on the EXEC->FIN edge so they appear with DONE;
  // a reserved op leaves RESULT/ZERO untouched.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_result <= '0;
      r_zero   <= 1'b1;
      r_err    <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if ((r_state == S_EXEC) && w_last) begin
        if (w_reserved) begin
          r_err <= 1'b1;
        end else begin
          r_result <= w_res;
          r_zero   <= (w_res == '0);
        end
      end
    end
  end

  assign RESULT = r_result;
  assign ZERO   = r_zero;
  assign ERR    = r_err;
  assign DONE   = (r_state == S_FIN);
  assign BUSY   = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

  localparam int DW = 8;
  localparam int SW = $clog2(DW);

  logic          CLK = 1'b0;
  logic          RESET;
  logic          START;
  logic [2:0]    SELECT;
  logic [DW-1:0] DATA1;
  logic [DW-1:0] DATA2;
  logic [DW-1:0] RESULT;
  logic          ZERO;
  logic          BUSY;
  logic          DONE;
  logic          ERR;

  alu_seq #(.DATA_W(DW)) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .START  (START),
    .SELECT (SELECT),
    .DATA1  (DATA1),
    .DATA2  (DATA2),
    .RESULT (RESULT),
    .ZERO   (ZERO),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .ERR    (ERR)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] res;
    logic          zero;
    logic          err;
    int            lat;
    int            acc;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] model_res = '0;
  int            n_checks = 0;
  int            n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
  endtask

  // Reference model: plain arithmetic on the opcode's definition.
  task automatic model(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       output logic [DW-1:0] r, output logic e, output int lat);
    int k;
    k   = int'(b) % (1 << SW);
    r   = model_res;
    e   = 1'b0;
    lat = 2;
    case (op)
      3'd0: r = b;
      3'd1: r = DW'(int'(a) + int'(b));
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: begin r = a << k; lat = ((k > 1) ? k : 1) + 1; end
      3'd5: begin r = a >> k; lat = ((k > 1) ? k : 1) + 1; end
      3'd6: begin r = DW'($signed(a) >>> k); lat = ((k > 1) ? k : 1) + 1; end
      default: begin
`ifdef ALU_SEQ_MUL_EN
        r   = DW'(int'(a) * int'(b));
        lat = DW + 1;
`else
        e = 1'b1;
`endif
      end
    endcase
    if (!e) model_res = r;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (BUSY && t < 200) begin
      @(posedge CLK); #1;
      t++;
    end
    chk("idle_timeout", 32'(BUSY), 32'd0);
  endtask

  task automatic issue(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    exp_t e;
    wait_idle();
    START = 1'b1; SELECT = op; DATA1 = a; DATA2 = b;
    @(posedge CLK); #1;
    START = 1'b0;
    SELECT = 3'($urandom); DATA1 = DW'($urandom); DATA2 = DW'($urandom);
    model(op, a, b, e.res, e.err, e.lat);
    e.zero = (e.res == '0);
    e.acc  = cyc;
    sb.push_back(e);
  endtask

  // START while busy: must be ignored, so nothing is pushed.
  task automatic poke(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    START = 1'b1; SELECT = op; DATA1 = a; DATA2 = b;
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  always @(negedge CLK) begin : monitor
    exp_t e;
    if (!RESET && DONE) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("result", 32'(RESULT), 32'(e.res));
        chk("zero", 32'(ZERO), 32'(e.zero));
        chk("err", 32'(ERR), 32'(e.err));
        chk("latency", 32'(cyc + 1 - e.acc), 32'(e.lat));
        chk("busy_at_done", 32'(BUSY), 32'd1);
        $display("txn: result=%h zero=%b err=%b lat=%0d", RESULT, ZERO, ERR, cyc + 1 - e.acc);
      end
    end else if (!RESET && ERR) begin
      chk("err_without_done", 32'(ERR), 32'd0);
    end
  end

  initial begin
    logic [2:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    RESET = 1'b1; START = 1'b0; SELECT = '0; DATA1 = '0; DATA2 = '0;
    #2;
    chk("rst_result", 32'(RESULT), 32'd0);
    chk("rst_zero", 32'(ZERO), 32'd1);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_err", 32'(ERR), 32'd0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(posedge CLK); #1;

    issue(3'd1, 8'hF0, 8'h20);           // ADD -> 10
    issue(3'd6, 8'h90, 8'h03);           // SRA -> F2
    issue(3'd5, 8'h90, 8'h03);           // SRL -> 12
    issue(3'd4, 8'h90, 8'h08);           // SLL k=0 -> 90
    issue(3'd4, 8'h0B, 8'h05);           // SLL k=5 with ignored START
    poke(3'd1, 8'h55, 8'h66);
    poke(3'd0, 8'hAA, 8'h00);

    // Reset in the third EXEC cycle of SRL k=7.
    issue(3'd5, 8'hC3, 8'h07);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    #2 RESET = 1'b1;
    #1;
    chk("midrst_result", 32'(RESULT), 32'd0);
    chk("midrst_zero", 32'(ZERO), 32'd1);
    chk("midrst_busy", 32'(BUSY), 32'd0);
    chk("midrst_done", 32'(DONE), 32'd0);
    chk("midrst_err", 32'(ERR), 32'd0);
    sb.delete();
    model_res = '0;
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(posedge CLK); #1;

    issue(3'd1, 8'h01, 8'h01);           // ADD -> 2
    issue(3'd7, 8'h0D, 8'h0B);           // MUL -> 8F, or reserved
    issue(3'd0, 8'h5A, 8'h00);           // FORWARD 0 -> ZERO
    issue(3'd2, 8'hF3, 8'h3C);           // back-to-back AND
    issue(3'd6, 8'h7F, 8'h07);           // SRA positive, max k

    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom);
      a  = DW'($urandom);
      b  = DW'($urandom);
      issue(op, a, b);
      if ($urandom_range(3, 0) == 0) poke(3'($urandom), DW'($urandom), DW'($urandom));
    end

    wait_idle();
    repeat (4) @(posedge CLK);
    #1;
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, clocked successor to the processor's combinational ALU.
- Single-cycle ops: FORWARD, ADD, AND, OR.
- Multi-cycle iterative ops: logical left shift, logical right shift, arithmetic right shift, and an optional shift-add multiply.
- Sits between the register file and the writeback mux; the control unit drives a START/DONE handshake and stalls the PC while BUSY is high.

Parameters:
- DATA_W, 8, operand and result width in bits; must be at least 2.
- SHAMT_W, $clog2(DATA_W), number of DATA2 LSBs used as the shift amount (derived; not overridden).

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RESET  input  1  asynchronous, active-high reset.
- START  input  1  one-cycle request; sampled only in IDLE.
- SELECT  input  3  ALUOP; sampled with START.
- DATA1  input  DATA_W  operand 1; captured on an accepted START.
- DATA2  input  DATA_W  operand 2 / shift amount; captured on an accepted START.
- RESULT  output  DATA_W  registered result; holds until the next DONE.
- ZERO  output  1  registered; equals (RESULT == 0); updates together with RESULT.
- BUSY  output  1  high from the cycle after an accepted START until the DONE cycle, inclusive.
- DONE  output  1  one-cycle pulse; RESULT and ZERO are valid in this cycle.
- ERR  output  1  pulses with DONE when SELECT is reserved.

Behaviour:
- Reset values: RESULT=0, ZERO=1, BUSY=0, DONE=0, ERR=0, state=IDLE. Reset takes effect immediately, including mid-operation; the in-flight op is abandoned with no DONE.
- States:
  - IDLE: START=1 captures DATA1, DATA2, SELECT and moves to EXEC. START=0 stays in IDLE.
  - EXEC: runs the op and moves to FIN once the op completes.
  - FIN: DONE=1, returns to IDLE next cycle.
- Opcodes:
  - 000 FORWARD: RESULT = DATA2.
  - 001 ADD: DATA1+DATA2 mod 2^DATA_W; carry discarded.
  - 010 AND.
  - 011 OR.
  - 100 SLL.
  - 101 SRL.
  - 110 SRA.
  - 111 MUL (optional; see below).
- Single-cycle ops: one EXEC cycle. START accepted at edge n gives DONE at edge n+2, i.e. latency 2.
- Shifts:
  - Amount k = DATA2[SHAMT_W-1:0]; upper DATA2 bits are ignored.
  - One bit per EXEC cycle using a down-counter; EXEC lasts max(k,1) cycles, so latency = max(k,1)+1.
  - SRA replicates the MSB; SRL and SLL fill with 0.
  - k=0 returns DATA1 unchanged with latency 2.
- START while BUSY=1 (EXEC or FIN) is ignored, not queued.
- Back-to-back: START asserted in the cycle after DONE (state IDLE) is accepted.
- Operand inputs may change freely after acceptance; only the captured copies are used.
- Reserved SELECT: RESULT is left unchanged, ERR=1 with DONE, latency 2.
- RESULT changes only at the edge that raises DONE; it never shows intermediate shift or multiply values.

Optional Feature:
- Macro: ALU_SEQ_MUL_EN.
- Defined: SELECT=111 is an unsigned shift-add multiply over exactly DATA_W EXEC cycles (latency DATA_W+1). RESULT is the low DATA_W bits of the product; high bits are discarded.
- Undefined: 111 is reserved (ERR pulse, RESULT held). No multiplier accumulator is synthesised.

Decomposition:
- Shared package/include alu_defs holds:
  - ALUOP localparams: ALU_FWD, ALU_ADD, ALU_AND, ALU_OR, ALU_SLL, ALU_SRL, ALU_SRA, ALU_MUL.
  - State encodings: S_IDLE, S_EXEC, S_FIN.
  - The control unit includes the same file.
- One sub-module, alu_iter_unit: the captured-operand registers, iteration counter and shift/multiply-accumulate datapath, with load/step/last signals.
- The FSM, handshake and result/flag registers stay in alu_seq.

Test Plan:
- DATA_W=8, ADD 8'hF0+8'h20, START one cycle -> DONE 2 edges later, RESULT=8'h10, ZERO=0, BUSY high for 2 cycles.
- SRA DATA1=8'h90, DATA2=8'h03 -> DONE after 4 edges, RESULT=8'hF2. The same operands with SRL -> 8'h12. SLL with DATA2=8'h08 (k=0) -> RESULT=8'h90, latency 2.
- START pulsed again mid-SLL (k=5) with different operands -> ignored; a single DONE with the first op's result, no second DONE.
- RESET asserted during the 3rd EXEC cycle of SRL k=7 -> outputs return to reset values immediately; no DONE; the next ADD 1+1 completes normally with RESULT=2.
- With ALU_SEQ_MUL_EN defined: MUL 8'h0D*8'h0B -> RESULT=8'h8F after 9 edges. Without it: SELECT=111 -> ERR=1 with DONE, RESULT unchanged.
- DATA_W=16, FORWARD 16'h0000 -> RESULT=0 and ZERO=1. A back-to-back AND issued in the cycle after DONE is accepted.
